// File: rtl/dl_pkg.sv
// Shared ioctl download bus widths and the byte-split FSM states.
// Imported by the ioctl interface and by every download-loaded ROM bank.
package dl_pkg;

  localparam int IOCTL_AW = 27;
  localparam int IOCTL_DW = 16;

  typedef enum logic [1:0] {
    IDLE,
    WR_LO,
    WR_HI
  } state_e;

endpackage

// File: rtl/dl_rom_bank_if.sv
// HPS ioctl download bus: download flag, byte address, data, write strobe.
// master drives the bus (HPS side), slave receives it (ROM bank side).
interface dl_rom_bank_if;
  import dl_pkg::*;

  logic                ioctl_download;
  logic [IOCTL_AW-1:0] ioctl_addr;
  logic [IOCTL_DW-1:0] ioctl_dout;
  logic                ioctl_wr;

  modport master (
    output ioctl_download,
    output ioctl_addr,
    output ioctl_dout,
    output ioctl_wr
  );

  modport slave (
    input ioctl_download,
    input ioctl_addr,
    input ioctl_dout,
    input ioctl_wr
  );

endinterface

// File: rtl/ram.sv
// Generic single-port RAM with synchronous read (read-before-write).
// Ports: clk, we, addr, din, dout (registered); contents are never reset.
module ram #(
  parameter int AW = 13,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= din;
    dout <= mem[addr];
  end

endmodule

// File: rtl/dl_rom_bank.sv
// Download-loaded ROM bank: captures ioctl words in its window, serves CPU reads.
// Ports: clk_sys, reset_n, cpu_ab/rom_data, ioctl (slave), load status outputs.
module dl_rom_bank
  import dl_pkg::*;
#(
  parameter int                  AW      = 13,
  parameter int                  CPU_AW  = 16,
  parameter logic [IOCTL_AW-1:0] BASE    = 27'h8000,
  parameter bit                  WIDE_IO = 1'b1
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic [CPU_AW-1:0] cpu_ab,
  output logic [7:0]        rom_data,
  dl_rom_bank_if.slave      ioctl,
  output logic              rom_ready,
  output logic              rom_overrun,
  output logic [AW:0]       rom_bytes,
  output logic [7:0]        rom_csum
);

  localparam logic [IOCTL_AW:0] WIN_LO = {1'b0, BASE};
  localparam logic [IOCTL_AW:0] WIN_HI =
    WIN_LO + (IOCTL_AW+1)'(2**AW);
  localparam logic [AW:0] CNT_MAX = {1'b1, {AW{1'b0}}};

  state_e              state_q, state_d;
  logic [AW-1:0]       off_q, off_d;
  logic [IOCTL_DW-1:0] dat_q, dat_d;
  logic [AW:0]         cnt_q, cnt_d;
  logic [7:0]          sum_q, sum_d;
  logic                rdy_q, rdy_d;
  logic                ovr_q, ovr_d;
  logic                pend_q, pend_d;
  logic                dl_q, rdv_q;

  logic [IOCTL_AW-1:0] rel;
  logic [AW-1:0]       win_off, wr_addr, ram_addr;
  logic [7:0]          wr_byte, ram_q;
  logic                rise, fall, hit, busy;
  logic                ram_we, pend_now;
  logic                unused_bits;

  assign rise = ioctl.ioctl_download & ~dl_q;
  assign fall = ~ioctl.ioctl_download & dl_q;
  assign busy = (state_q != IDLE);
  assign hit  = ioctl.ioctl_download
              & ioctl.ioctl_wr
              & ({1'b0, ioctl.ioctl_addr} >= WIN_LO)
              & ({1'b0, ioctl.ioctl_addr} < WIN_HI);

  assign rel = ioctl.ioctl_addr - BASE;
  assign unused_bits =
    ^{cpu_ab[CPU_AW-1:AW], rel[IOCTL_AW-1:AW]};

  // Wide words are always stored on an even byte pair.
  always_comb begin
    win_off = rel[AW-1:0];
    if (WIDE_IO) win_off[0] = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    off_d   = off_q;
    dat_d   = dat_q;
    ram_we  = 1'b0;
    wr_addr = off_q;
    wr_byte = dat_q[7:0];
    cnt_d   = rise ? '0 : cnt_q;
    sum_d   = rise ? '0 : sum_q;
    rdy_d   = rise ? 1'b0 : rdy_q;
    ovr_d   = rise ? 1'b0 : ovr_q;
    pend_d  = rise ? 1'b0 : pend_q;
    unique case (state_q)
      IDLE: begin
        if (hit) begin
          state_d = WR_LO;
          off_d   = win_off;
          dat_d   = ioctl.ioctl_dout;
        end
      end
      WR_LO: begin
        ram_we  = 1'b1;
        state_d = (WIDE_IO && off_q != '1)
                ? WR_HI : IDLE;
      end
      WR_HI: begin
        ram_we  = 1'b1;
        wr_addr = off_q + AW'(1);
        wr_byte = dat_q[15:8];
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (hit && busy) ovr_d = 1'b1;
    if (ram_we) begin
      if (cnt_d != CNT_MAX) cnt_d = cnt_d + (AW+1)'(1);
      sum_d = sum_d + wr_byte;
    end
    // A download that ends mid-word flags ready once the word lands.
    pend_now = pend_q | (fall & busy);
    if (fall && !busy) rdy_d = (cnt_q != '0);
    if (pend_now && busy && state_d == IDLE) begin
      rdy_d  = 1'b1;
      pend_d = 1'b0;
    end else if (fall && busy) begin
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      off_q   <= '0;
      dat_q   <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      rdy_q   <= 1'b0;
      ovr_q   <= 1'b0;
      pend_q  <= 1'b0;
      dl_q    <= 1'b0;
      rdv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      off_q   <= off_d;
      dat_q   <= dat_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      rdy_q   <= rdy_d;
      ovr_q   <= ovr_d;
      pend_q  <= pend_d;
      dl_q    <= ioctl.ioctl_download;
      rdv_q   <= ~busy;
    end
  end

  assign ram_addr = busy ? wr_addr : cpu_ab[AW-1:0];

  ram #(.AW(AW), .DW(8)) u_ram (
    .clk  (clk_sys),
    .we   (ram_we),
    .addr (ram_addr),
    .din  (wr_byte),
    .dout (ram_q)
  );

  // rdv_q marks that the RAM output came from a CPU-address read.
  assign rom_data = (rdv_q && !busy && !ioctl.ioctl_download)
                  ? ram_q : 8'h00;

  assign rom_ready   = rdy_q;
  assign rom_overrun = ovr_q;
  assign rom_bytes   = cnt_q;
  assign rom_csum    = sum_q;

endmodule
